uart_tx_arbiter: RTL and testbench

Shares one UART byte transmitter between N_REQ byte-stream requesters. Requesters send packets: runs of bytes, with the final byte flagged by req_last. A round-robin arbiter locks the transmitter to one requester for a whole packet. The block drives the transmitter's start/data handshake one byte at a time and waits for its finish pulse. A watchdog releases the lock if the transmitter or a requester stalls.

---
 rtl/uart_tx_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one UART byte transmitter among N_REQ byte-stream requesters, locked per packet.
// Latency: a valid seen in IDLE gives tx_start/req_ready one cycle later; a finish gives the next start two cycles later.
// Backpressure: one byte in flight; req_ready pulses only when a byte is handed to the transmitter, and a watchdog releases stalls.
//
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   req_valid     - [N_REQ] requester i presents a byte (held until its req_ready pulse)
//   req_data      - [8*N_REQ] byte of requester i in bits [8i+7:8i]
//   req_last      - [N_REQ] presented byte ends its packet
//   req_ready     - [N_REQ] registered one-cycle consume pulse
//   tx_data       - [8] byte to the transmitter, stable from start until finish
//   tx_start      - registered one-cycle start pulse
//   tx_finish     - one-cycle pulse from the transmitter after the stop bit
//   grant         - [N_REQ] one-hot owner, zero when idle
//   busy          - arbiter is not idle
//   timeout_err   - one-cycle pulse when the watchdog expires
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 200000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_finish,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               timeout_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no owner
    S_WAIT = 2'd1,  // byte in flight, waiting for tx_finish
    S_HOLD = 2'd2   // packet locked, waiting for the owner's next byte
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic             last_q, last_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic             timeout_err_q, timeout_err_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [WW-1:0]    wd_q, wd_d;

  logic [PW:0]      pick;
  logic             pick_vld;
  logic [PW-1:0]    pick_idx;
  logic [PW-1:0]    ptr_adv;
  logic             load_en;
  logic [PW-1:0]    load_idx;

  // Round-robin search starting at the pointer. Walking the offsets from the
  // far end down lets the nearest valid requester overwrite later ones.
  // Result is {found, index}.
  function automatic logic [PW:0] rr_pick(input logic [N_REQ-1:0] v,
                                          input logic [PW-1:0]    p);
    logic [PW:0] r;
    int          j;
    r = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(p) + k) % N_REQ;
      if (v[j]) begin
        r = {1'b1, PW'(j)};
      end
    end
    return r;
  endfunction

  always_comb begin
    pick     = rr_pick(req_valid, ptr_q);
    pick_vld = pick[PW];
    pick_idx = pick[PW-1:0];
    // Pointer moves to the requester after the one releasing the lock.
    ptr_adv  = PW'((int'(owner_q) + 1) % N_REQ);
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_d        = last_q;
    tx_data_d     = tx_data_q;
    ptr_d         = ptr_q;
    wd_d          = wd_q;
    tx_start_d    = 1'b0;
    req_ready_d   = '0;
    timeout_err_d = 1'b0;
    load_en       = 1'b0;
    load_idx      = owner_q;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          load_en  = 1'b1;
          load_idx = pick_idx;
        end
      end

      S_WAIT: begin
        // A finish on the expiry cycle wins over the watchdog.
        if (tx_finish) begin
          if (last_q) begin
            state_d = S_IDLE;
            grant_d = '0;
            ptr_d   = ptr_adv;
          end else begin
            state_d = S_HOLD;
            wd_d    = '0;
          end
        end else if (wd_q == WD_LAST) begin
          state_d       = S_IDLE;
          grant_d       = '0;
          ptr_d         = ptr_adv;
          timeout_err_d = 1'b1;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end

      S_HOLD: begin
        // Only the owner can continue; tx_finish here is stale and ignored.
        if (req_valid[owner_q]) begin
          load_en  = 1'b1;
          load_idx = owner_q;
        end else if (wd_q == WD_LAST) begin
          state_d       = S_IDLE;
          grant_d       = '0;
          ptr_d         = ptr_adv;
          timeout_err_d = 1'b1;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    // Hand one byte to the transmitter: shared by IDLE and HOLD.
    if (load_en) begin
      state_d               = S_WAIT;
      grant_d               = '0;
      grant_d[load_idx]     = 1'b1;
      owner_d               = load_idx;
      tx_data_d             = req_data[8*load_idx +: 8];
      last_d                = req_last[load_idx];
      tx_start_d            = 1'b1;
      req_ready_d[load_idx] = 1'b1;
      wd_d                  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      last_q        <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_start_q    <= 1'b0;
      req_ready_q   <= '0;
      timeout_err_q <= 1'b0;
      ptr_q         <= '0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      req_ready_q   <= req_ready_d;
      timeout_err_q <= timeout_err_d;
      ptr_q         <= ptr_d;
      wd_q          <= wd_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign grant       = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: directed self-checking bench for uart_tx_arbiter (N_REQ = 4, TIMEOUT = 50).
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: the bench plays both the requesters and the transmitter finish pulse.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_finish;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(50)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_finish   (tx_finish),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic present(input int r, input logic [7:0] d, input logic l);
    req_valid[r]       = 1'b1;
    req_data[8*r +: 8] = d;
    req_last[r]        = l;
  endtask

  task automatic finish_pulse();
    tx_finish = 1'b1;
    step();
    tx_finish = 1'b0;
  endtask

  // Waits (bounded) for a start, checks the handshake, then retires the byte.
  task automatic expect_start(input string tag, input int r, input logic [7:0] d,
                              input int max_wait, output int waited);
    waited = 0;
    while (tx_start !== 1'b1 && waited < max_wait) begin
      step();
      waited++;
    end
    chk_eq({tag, "_start"}, 32'(tx_start), 32'd1);
    chk_eq({tag, "_grant"}, 32'(grant), 32'(1 << r));
    chk_eq({tag, "_data"}, 32'(tx_data), 32'(d));
    chk_eq({tag, "_ready"}, 32'(req_ready), 32'(1 << r));
    step();
    chk_eq({tag, "_start_clr"}, 32'(tx_start), 32'd0);
    chk_eq({tag, "_ready_clr"}, 32'(req_ready), 32'd0);
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic one_byte(input string tag, input int r, input logic [7:0] d);
    int w;
    present(r, d, 1'b1);
    expect_start(tag, r, d, 5, w);
    chk_eq({tag, "_lat"}, w, 1);
    repeat (3) step();
    finish_pulse();
    chk_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int w;
    int cnt;
    int rr_seq[8];
    rr_seq = '{0, 1, 2, 3, 0, 1, 2, 3};

    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_finish = 1'b0;
    step(); step();
    rst = 1'b0;
    chk_eq("rst_grant", 32'(grant), 32'd0);
    chk_eq("rst_ready", 32'(req_ready), 32'd0);
    chk_eq("rst_start", 32'(tx_start), 32'd0);
    chk_eq("rst_data", 32'(tx_data), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_tmo", 32'(timeout_err), 32'd0);

    // Single byte from requester 1, finish after 10 cycles.
    present(1, 8'hA5, 1'b1);
    expect_start("single", 1, 8'hA5, 5, w);
    chk_eq("single_lat", w, 1);
    chk_eq("single_busy", 32'(busy), 32'd1);
    repeat (9) step();
    finish_pulse();
    chk_eq("single_idle", 32'(busy), 32'd0);
    chk_eq("single_grant0", 32'(grant), 32'd0);

    // Pointer is now 2: with 1 and 2 valid, 2 wins, then 1, then 3 alone.
    present(1, 8'h5A, 1'b1);
    one_byte("ptr2", 2, 8'h3C);
    one_byte("ptr3", 1, 8'h5A);
    one_byte("ptr_to0", 3, 8'h07);

    // Packet lock: requester 0 sends three bytes while requester 2 waits.
    present(2, 8'h77, 1'b1);
    present(0, 8'h11, 1'b0);
    expect_start("pkt0", 0, 8'h11, 5, w);
    present(0, 8'h22, 1'b0);
    repeat (4) step();
    finish_pulse();
    chk_eq("pkt_hold_busy", 32'(busy), 32'd1);
    chk_eq("pkt_hold_grant", 32'(grant), 32'd1);
    expect_start("pkt1", 0, 8'h22, 5, w);
    chk_eq("pkt1_lat", w, 1);
    present(0, 8'h33, 1'b1);
    repeat (4) step();
    finish_pulse();
    expect_start("pkt2", 0, 8'h33, 5, w);
    chk_eq("pkt2_lat", w, 1);
    repeat (4) step();
    finish_pulse();
    expect_start("pkt_r2", 2, 8'h77, 5, w);
    chk_eq("pkt_r2_lat", w, 1);
    repeat (2) step();
    finish_pulse();

    // Pointer 3 -> 0, then round-robin with all four valid.
    one_byte("rr_pre", 3, 8'h08);
    for (int r = 0; r < 4; r++) present(r, 8'hC0 + 8'(r), 1'b1);
    for (int i = 0; i < 8; i++) begin
      expect_start("rr", rr_seq[i], 8'hC0 + 8'(rr_seq[i]), 5, w);
      chk_eq("rr_lat", w, 1);
      if (i < 4) present(rr_seq[i], 8'hC0 + 8'(rr_seq[i]), 1'b1);
      repeat (2) step();
      finish_pulse();
    end
    chk_eq("rr_done_idle", 32'(busy), 32'd0);

    // Transmitter stall: timeout_err 50 cycles after tx_start.
    present(1, 8'h99, 1'b1);
    expect_start("stall", 1, 8'h99, 5, w);
    cnt = 1;
    while (timeout_err !== 1'b1 && cnt < 100) begin
      step();
      cnt++;
    end
    chk_eq("stall_tmo_cycles", cnt, 50);
    chk_eq("stall_grant", 32'(grant), 32'd0);
    chk_eq("stall_busy", 32'(busy), 32'd0);
    chk_eq("stall_ready", 32'(req_ready), 32'd0);
    step();
    chk_eq("stall_tmo_pulse", 32'(timeout_err), 32'd0);
    finish_pulse();
    chk_eq("late_fin_busy", 32'(busy), 32'd0);
    chk_eq("late_fin_start", 32'(tx_start), 32'd0);
    present(0, 8'h4E, 1'b1);
    one_byte("stall_ptr", 2, 8'h2B);
    expect_start("stall_r0", 0, 8'h4E, 5, w);
    repeat (2) step();
    finish_pulse();

    // Finish on the expiry cycle counts as finish.
    present(2, 8'h5C, 1'b1);
    expect_start("edge", 2, 8'h5C, 5, w);
    repeat (48) step();
    finish_pulse();
    chk_eq("edge_tmo", 32'(timeout_err), 32'd0);
    chk_eq("edge_idle", 32'(busy), 32'd0);
    step();
    chk_eq("edge_tmo_next", 32'(timeout_err), 32'd0);

    // Hold stall: requester 3 sends a non-last byte then goes quiet.
    present(3, 8'hE1, 1'b0);
    expect_start("hold", 3, 8'hE1, 5, w);
    repeat (2) step();
    finish_pulse();
    cnt = 0;
    present(0, 8'h0F, 1'b1);
    repeat (10) begin
      step();
      cnt++;
    end
    chk_eq("hold_grant", 32'(grant), 32'h8);
    chk_eq("hold_busy", 32'(busy), 32'd1);
    while (timeout_err !== 1'b1 && cnt < 100) begin
      step();
      cnt++;
    end
    chk_eq("hold_tmo_cycles", cnt, 50);
    chk_eq("hold_tmo_grant", 32'(grant), 32'd0);
    expect_start("hold_r0", 0, 8'h0F, 5, w);
    chk_eq("hold_r0_lat", w, 1);
    repeat (2) step();
    finish_pulse();

    // Reset mid-WAIT (pointer is 1 before reset).
    present(2, 8'h42, 1'b1);
    expect_start("mid", 2, 8'h42, 5, w);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_eq("mrst_grant", 32'(grant), 32'd0);
    chk_eq("mrst_busy", 32'(busy), 32'd0);
    chk_eq("mrst_data", 32'(tx_data), 32'd0);
    chk_eq("mrst_start", 32'(tx_start), 32'd0);
    cnt = 0;
    repeat (5) begin
      step();
      if (tx_start !== 1'b0) cnt++;
    end
    chk_eq("mrst_no_start", cnt, 0);
    present(3, 8'h93, 1'b1);
    one_byte("mrst_ptr0", 0, 8'h90);
    expect_start("mrst_r3", 3, 8'h93, 5, w);
    repeat (2) step();
    finish_pulse();
    chk_eq("final_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
